// File: rtl/speck_decrypt_core.sv
// speck_decrypt_core: iterative SPECK-128/128 decryption, one round per clock.
// A start in IDLE latches ciphertext/key, the forward key schedule fills a
// local round-key buffer, then inverse rounds consume it in reverse order.
// Optional feature macro: SPECK_DEC_KEY_CACHE_EN (skip key expansion when the
// key matches the last completed expansion).
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   signal_start    one-cycle request, sampled only in IDLE
//   key             [127:64] l0, [63:0] k0
//   ciphertext      [127:64] x,  [63:0] y
//   plaintext       result (same packing), held until next completion
//   finished        one-cycle pulse when plaintext is valid
//   busy            high while not IDLE
//   state_response  current state encoding
module speck_decrypt_core #(
    parameter int unsigned NR_ROUNDS = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         signal_start,
    input  logic [127:0] key,
    input  logic [127:0] ciphertext,
    output logic [127:0] plaintext,
    output logic         finished,
    output logic         busy,
    output logic [3:0]   state_response
);

    localparam int unsigned CTR_W = (NR_ROUNDS > 2) ? $clog2(NR_ROUNDS) : 1;
    localparam logic [CTR_W-1:0] CTR_LAST   = CTR_W'(NR_ROUNDS - 1);
    localparam logic [CTR_W-1:0] CTR_PENULT = CTR_W'(NR_ROUNDS - 2);

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        KEY_EXPAND = 4'd1,
        DECRYPT    = 4'd2,
        DONE       = 4'd3
    } state_t;

    state_t state, state_nxt;

    logic [63:0]      x_q, y_q, l_q, k_q;
    logic [63:0]      x_d, y_d, l_d, k_d;
    logic [CTR_W-1:0] ctr_q, ctr_d;
    logic [127:0]     plaintext_d;
    logic             finished_d;

    logic [63:0]      key_buf [NR_ROUNDS];
    logic             buf_we;
    logic [CTR_W-1:0] buf_addr;
    logic [63:0]      buf_data;

    logic             cache_hit_c;

`ifdef SPECK_DEC_KEY_CACHE_EN
    logic [127:0] cache_key_q;
    logic         cache_valid_q;
    assign cache_hit_c = cache_valid_q && (key == cache_key_q);
`else
    assign cache_hit_c = 1'b0;
`endif

    // Forward key-schedule step and inverse round, evaluated from current regs.
    logic [63:0] l_next, k_next, rk, y_inv, x_inv, x_xor_k;
    always_comb begin
        l_next  = (k_q + {l_q[7:0], l_q[63:8]}) ^ 64'(ctr_q);
        k_next  = {k_q[60:0], k_q[63:61]} ^ l_next;
        rk      = key_buf[ctr_q];
        y_inv   = x_q ^ y_q;
        y_inv   = {y_inv[2:0], y_inv[63:3]};
        x_xor_k = (x_q ^ rk) - y_inv;
        x_inv   = {x_xor_k[55:0], x_xor_k[63:56]};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (signal_start) state_nxt = cache_hit_c ? DECRYPT : KEY_EXPAND;
            KEY_EXPAND: if (ctr_q == CTR_PENULT) state_nxt = DECRYPT;
            DECRYPT:    if (ctr_q == '0) state_nxt = DONE;
            DONE:       state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Datapath / output next values.
    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        l_d         = l_q;
        k_d         = k_q;
        ctr_d       = ctr_q;
        plaintext_d = plaintext;
        finished_d  = 1'b0;
        buf_we      = 1'b0;
        buf_addr    = ctr_q;
        buf_data    = k_q;
        case (state)
            IDLE: begin
                if (signal_start) begin
                    x_d      = ciphertext[127:64];
                    y_d      = ciphertext[63:0];
                    l_d      = key[127:64];
                    k_d      = key[63:0];
                    ctr_d    = cache_hit_c ? CTR_LAST : '0;
                    buf_we   = 1'b1;
                    buf_addr = '0;
                    buf_data = key[63:0];
                end
            end
            KEY_EXPAND: begin
                buf_we   = 1'b1;
                buf_addr = ctr_q + CTR_W'(1);
                buf_data = k_next;
                l_d      = l_next;
                k_d      = k_next;
                ctr_d    = ctr_q + CTR_W'(1);
            end
            DECRYPT: begin
                x_d = x_inv;
                y_d = y_inv;
                if (ctr_q == '0) begin
                    plaintext_d = {x_inv, y_inv};
                    finished_d  = 1'b1;
                end else begin
                    ctr_d = ctr_q - CTR_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q       <= '0;
            y_q       <= '0;
            l_q       <= '0;
            k_q       <= '0;
            ctr_q     <= '0;
            plaintext <= '0;
            finished  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            l_q       <= l_d;
            k_q       <= k_d;
            ctr_q     <= ctr_d;
            plaintext <= plaintext_d;
            finished  <= finished_d;
            busy      <= (state_nxt != IDLE);
        end
    end

    assign state_response = state;

    // Round-key buffer; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (buf_we) key_buf[buf_addr] <= buf_data;
    end

`ifdef SPECK_DEC_KEY_CACHE_EN
    // A miss invalidates the cache because buf[0] is overwritten; the new key
    // becomes valid only once its expansion has fully completed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_key_q   <= '0;
            cache_valid_q <= 1'b0;
        end else if (state == IDLE && signal_start && !cache_hit_c) begin
            cache_key_q   <= key;
            cache_valid_q <= 1'b0;
        end else if (state == KEY_EXPAND && state_nxt == DECRYPT) begin
            cache_valid_q <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/speck_decrypt_core.md
# speck_decrypt_core

Iterative SPECK-128/128 decryption core: the inverse of the encrypt path built from `key_schedule` and `round_encrypt`. It accepts a 128-bit ciphertext and key on a `signal_start`/`finished` handshake. It expands all round keys forward into a local buffer, then applies the inverse rounds in reverse key order, one round per clock. It sits beside the encrypt chain so the team can round-trip data through the hardware.

## Interface
- `NR_ROUNDS`, 32: number of rounds and round keys; legal range 2..32.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `signal_start` in 1: one-cycle request; sampled only in IDLE.
- `key` in 128: `[127:64]` = l0, `[63:0]` = k0.
- `ciphertext` in 128: `[127:64]` = x, `[63:0]` = y.
- `plaintext` out 128: result with the same x/y packing; holds its value until the next completion.
- `finished` out 1: registered one-cycle pulse when `plaintext` is valid.
- `busy` out 1: high whenever state ≠ IDLE.
- `state_response` out 4: current state encoding (see Operation).

## Operation
- Word size 64; all add/sub mod 2^64; ROR/ROL are rotations on 64-bit words.
- Key schedule (forward), for i = 0..NR_ROUNDS-2:
  - l(i+1) = (k(i) + ROR(l(i),8)) ^ i, with i zero-extended to 64 bits.
  - k(i+1) = ROL(k(i),3) ^ l(i+1).
  - Each k(i) is stored in a 64-bit × NR_ROUNDS buffer.
- Inverse round with key k:
  - y' = ROR(x ^ y, 3)
  - x' = ROL((x ^ k) - y', 8)
- States (`state_response`): IDLE=0, KEY_EXPAND=1, DECRYPT=2, DONE=3.
- IDLE:
  - On `signal_start`=1, latch `ciphertext` into the x/y working registers, latch l0, and write k0 to buf[0]. Set ctr=0.
  - Go to KEY_EXPAND, or to DECRYPT when the cache hits (see Configuration).
- KEY_EXPAND:
  - Each edge writes buf[ctr+1] and increments ctr.
  - On the edge that writes buf[NR_ROUNDS-1], set ctr=NR_ROUNDS-1 and go to DECRYPT.
- DECRYPT:
  - Each edge applies the inverse round with buf[ctr] and decrements ctr.
  - On the edge that uses buf[0], load `plaintext` with the result, set `finished`=1, and go to DONE.
- DONE: on the next edge clear `finished` and go to IDLE.
- `signal_start` outside IDLE is ignored; it is not queued.
- `key` and `ciphertext` are don't-care after the start cycle.
- Reset values: `plaintext`=0, `finished`=0, `busy`=0, `state_response`=0, ctr=0, working registers=0.
- The key buffer need not be cleared by reset.

## Timing
- Start is sampled at edge E0.
- KEY_EXPAND occupies edges E1..E(N-1); DECRYPT occupies edges EN..E(2N-1).
- `finished` is high in the cycle after E(2N-1): latency 2N-1 cycles, which is 63 for N=32.
- Cache-hit path: DECRYPT occupies E1..EN; latency N cycles.
- `busy` rises in the cycle after E0 and falls in the cycle after the DONE edge.
- The earliest next accepted start is the edge following the DONE cycle.
- When `rst_n` falls mid-operation, all outputs return immediately to their reset values and any in-flight result is discarded. No `finished` pulse is produced for that request.

## Configuration
- `SPECK_DEC_KEY_CACHE_EN` defined:
  - A 128-bit last-key register plus a valid bit record the key used by the most recent *completed* expansion.
  - A start whose `key` equals the stored key while valid=1 skips KEY_EXPAND.
  - Valid is cleared by reset and set on entry to DECRYPT from KEY_EXPAND.
- `SPECK_DEC_KEY_CACHE_EN` undefined: every request runs KEY_EXPAND; no cache logic is synthesized.

## Test plan
- Reference vector: `key`=128'h0f0e0d0c0b0a09080706050403020100, `ciphertext`=128'ha65d9851797832657860fedf5c570d18, one start pulse.
  - Expect `plaintext`=128'h6c617669757165207469206564616d20.
  - Expect one `finished` pulse 63 cycles after start.
- Back-to-back with the same key, `SPECK_DEC_KEY_CACHE_EN` defined: the second request gives the correct plaintext with 32-cycle latency.
  - Then change the key: latency returns to 63.
  - Without the macro, all three requests take 63 cycles.
- Assert `signal_start` again at cycles 5 and 40 of an active request.
  - Expect no effect: a single `finished` and the correct result.
  - `state_response` must step through 1→2→3→0.
- Pulse `rst_n` low at cycle 20 of a request.
  - Expect outputs 0 immediately and no `finished`.
  - A following fresh request must return the reference plaintext. With the cache enabled, it must take the 63-cycle path.
- Run 1000 random key/plaintext pairs encrypted by the `round_encrypt`/`key_schedule` chain (or a golden model), then decrypted here.
  - Every decrypted plaintext must match the original.
  - Include the all-zero and all-ones keys.
